seq_mult_ctrl: RTL and testbench

Shift-and-add multiplier controller. It time-shares one WIDTH-bit ripple-carry adder (a chain of team full-adder slices) across WIDTH iterations to form an unsigned 2*WIDTH-bit product. A start/busy/done handshake sequences one multiplication at a time. Board tops drive operands from SW and show the product and status on LEDR.

---
 rtl/seq_mult_ctrl_if.sv | 14 +
 rtl/seq_mult_ctrl.sv | 102 ++++++++++
 tb/tb_seq_mult_ctrl.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/seq_mult_ctrl_if.sv
// rtl/seq_mult_ctrl_if.sv - start/busy/done handshake and operand/product bus for seq_mult_ctrl
interface seq_mult_ctrl_if #(parameter int WIDTH = 4);
  logic                 start;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   product;

  modport master (output start, output a, output b,
                  input busy, input done, input product);
  modport slave  (input start, input a, input b,
                  output busy, output done, output product);
endinterface

// File: rtl/seq_mult_ctrl.sv
// rtl/seq_mult_ctrl.sv - shift-and-add unsigned multiplier, one WIDTH-bit ripple adder shared over WIDTH iterations
module seq_mult_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic          clock,
  input  logic          reset,
  seq_mult_ctrl_if.slave bus
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic {IDLE = 1'b0, ADD = 1'b1} state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     m_q, m_d;
  logic [WIDTH-1:0]     p_hi_q, p_hi_d;
  logic [WIDTH-1:0]     q_q, q_d;
  logic [CW-1:0]        count_q, count_d;
  logic [2*WIDTH-1:0]   product_q, product_d;
  logic                 done_q, done_d;

  logic [WIDTH-1:0]     addend;
  logic [WIDTH-1:0]     sum;
  logic [WIDTH:0]       carry;
  logic                 last_iter;

  // Shared adder: chain of full-adder slices, carry-in tied low.
  assign addend   = q_q[0] ? m_q : '0;
  assign carry[0] = 1'b0;

  genvar i;
  generate
    for (i = 0; i < WIDTH; i++) begin : g_fa
      assign sum[i]     = p_hi_q[i] ^ addend[i] ^ carry[i];
      assign carry[i+1] = (p_hi_q[i] & addend[i]) | (carry[i] & (p_hi_q[i] ^ addend[i]));
    end
  endgenerate

  assign last_iter = (count_q == CW'(WIDTH - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      m_q       <= '0;
      p_hi_q    <= '0;
      q_q       <= '0;
      count_q   <= '0;
      product_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      m_q       <= m_d;
      p_hi_q    <= p_hi_d;
      q_q       <= q_d;
      count_q   <= count_d;
      product_q <= product_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (state_q == IDLE) begin
      if (bus.start) state_d = ADD;
    end else begin
      if (last_iter) state_d = IDLE;
    end
  end

  // The adder carry-out lands in P_hi's MSB as the pair shifts right.
  always_comb begin
    m_d       = m_q;
    p_hi_d    = p_hi_q;
    q_d       = q_q;
    count_d   = count_q;
    product_d = product_q;
    done_d    = 1'b0;
    if (state_q == IDLE) begin
      if (bus.start) begin
        m_d     = bus.a;
        q_d     = bus.b;
        p_hi_d  = '0;
        count_d = '0;
      end
    end else begin
      p_hi_d  = {carry[WIDTH], sum[WIDTH-1:1]};
      q_d     = {sum[0], q_q[WIDTH-1:1]};
      count_d = count_q + 1'b1;
      if (last_iter) begin
        product_d = {carry[WIDTH], sum, q_q[WIDTH-1:1]};
        done_d    = 1'b1;
      end
    end
  end

  always_comb begin
    bus.busy    = (state_q == ADD);
    bus.done    = done_q;
    bus.product = product_q;
  end

endmodule

// File: tb/tb_seq_mult_ctrl.sv
// tb/tb_seq_mult_ctrl.sv - randomized and directed bench for seq_mult_ctrl against a cycle-count product model
module tb_seq_mult_ctrl;

  localparam int W  = 4;
  localparam int W8 = 8;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clock = ~clock;

  seq_mult_ctrl_if #(.WIDTH(W))  bus4 ();
  seq_mult_ctrl_if #(.WIDTH(W8)) bus8 ();

  seq_mult_ctrl #(.WIDTH(W))  dut  (.clock(clock), .reset(reset), .bus(bus4));
  seq_mult_ctrl #(.WIDTH(W8)) dut8 (.clock(clock), .reset(reset), .bus(bus8));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: an accepted start yields a*b exactly W+1 edges later; busy in between.
  int          m_rem;
  logic [31:0] m_pend;
  logic [31:0] m_prod;
  logic        m_done;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_rem  = 0;
      m_prod = 0;
      m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_rem > 0) begin
        m_rem = m_rem - 1;
        if (m_rem == 0) begin
          m_prod = m_pend;
          m_done = 1'b1;
        end
      end else if (bus4.start) begin
        m_pend = 32'(bus4.a) * 32'(bus4.b);
        m_rem  = W;
      end
    end
  end

  always @(negedge clock) begin
    if (!reset) begin
      check("busy", 32'(bus4.busy), 32'(m_rem > 0));
      check("done", 32'(bus4.done), 32'(m_done));
      check("product", 32'(bus4.product), m_prod);
    end
  end

  task automatic run_op(input int av, input int bv, output logic [31:0] prod,
                        output int lat, output int busy_n);
    @(negedge clock);
    bus4.a = W'(av); bus4.b = W'(bv); bus4.start = 1'b1;
    lat = -1; busy_n = 0; prod = '0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clock);
      bus4.start = 1'b0;
      if (bus4.busy) busy_n++;
      if (bus4.done) begin
        lat = i; prod = 32'(bus4.product);
        break;
      end
    end
    if (lat < 0) check("op_timeout", 32'(0), 32'(1));
  endtask

  task automatic run_op8(input int av, input int bv, output logic [31:0] prod, output int lat);
    @(negedge clock);
    bus8.a = W8'(av); bus8.b = W8'(bv); bus8.start = 1'b1;
    lat = -1; prod = '0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clock);
      bus8.start = 1'b0;
      if (bus8.done) begin
        lat = i; prod = 32'(bus8.product);
        break;
      end
    end
    if (lat < 0) check("op8_timeout", 32'(0), 32'(1));
  endtask

  typedef struct { int a; int b; int p; } vec_t;

  initial begin
    logic [31:0] prod;
    int lat, busy_n, done_n;
    vec_t vecs[5];
    vecs[0] = '{3, 5, 15};
    vecs[1] = '{9, 12, 108};
    vecs[2] = '{0, 13, 0};
    vecs[3] = '{7, 0, 0};
    vecs[4] = '{1, 1, 1};

    bus4.start = 1'b0; bus4.a = '0; bus4.b = '0;
    bus8.start = 1'b0; bus8.a = '0; bus8.b = '0;
    repeat (2) @(negedge clock);
    check("rst_busy", 32'(bus4.busy), 32'(0));
    check("rst_done", 32'(bus4.done), 32'(0));
    check("rst_product", 32'(bus4.product), 32'(0));
    reset = 1'b0;

    run_op(15, 15, prod, lat, busy_n);
    check("p15x15", prod, 32'hE1);
    check("lat15x15", 32'(lat), 32'(5));
    check("busy15x15", 32'(busy_n), 32'(4));
    @(negedge clock);
    check("done_falls", 32'(bus4.done), 32'(0));
    check("prod_holds", 32'(bus4.product), 32'hE1);

    foreach (vecs[k]) begin
      run_op(vecs[k].a, vecs[k].b, prod, lat, busy_n);
      check("vec_product", prod, 32'(vecs[k].p));
      done_n = 0;
      repeat (6) begin
        @(negedge clock);
        if (bus4.done) done_n++;
      end
      check("vec_single_done", 32'(done_n), 32'(0));
    end

    // start held high: one result every W+1 cycles
    @(negedge clock);
    bus4.a = 4'd6; bus4.b = 4'd7; bus4.start = 1'b1;
    done_n = 0;
    for (int i = 1; i <= 15; i++) begin
      @(negedge clock);
      if (bus4.done) begin
        done_n++;
        check("held_period", 32'(i % 5), 32'(0));
        check("held_product", 32'(bus4.product), 32'd42);
      end
    end
    bus4.start = 1'b0;
    check("held_count", 32'(done_n), 32'(3));
    repeat (6) @(negedge clock);

    // start while busy is ignored
    @(negedge clock);
    bus4.a = 4'd2; bus4.b = 4'd3; bus4.start = 1'b1;
    done_n = 0;
    for (int i = 1; i <= 15; i++) begin
      @(negedge clock);
      bus4.start = (i == 2);
      if (i == 2) begin bus4.a = 4'd15; bus4.b = 4'd15; end
      if (bus4.done) begin
        done_n++;
        check("busy_start_product", 32'(bus4.product), 32'd6);
      end
    end
    check("busy_start_dones", 32'(done_n), 32'(1));

    // reset mid-operation aborts silently
    @(negedge clock);
    bus4.a = 4'd15; bus4.b = 4'd15; bus4.start = 1'b1;
    repeat (2) @(negedge clock);
    bus4.start = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    done_n = 0;
    repeat (10) begin
      @(negedge clock);
      if (bus4.done) done_n++;
    end
    check("abort_dones", 32'(done_n), 32'(0));
    check("abort_busy", 32'(bus4.busy), 32'(0));
    check("abort_product", 32'(bus4.product), 32'(0));
    run_op(4, 4, prod, lat, busy_n);
    check("p4x4", prod, 32'd16);

    // 8-bit build
    run_op8(255, 255, prod, lat);
    check("p8_max", prod, 32'hFE01);
    check("lat8", 32'(lat), 32'(9));
    run_op8(200, 100, prod, lat);
    check("p8_200x100", prod, 32'd20000);

    // random start/operand traffic, including starts while busy
    for (int n = 0; n < 400; n++) begin
      @(negedge clock);
      bus4.start = ($urandom_range(0, 2) == 0);
      bus4.a = W'($urandom_range(0, 15));
      bus4.b = W'($urandom_range(0, 15));
    end
    @(negedge clock);
    bus4.start = 1'b0;
    repeat (8) @(negedge clock);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
